// File: rtl/nr_recip_ctrl.sv
// nr_recip_ctrl: sequences a Newton-Raphson reciprocal (about 2^32/d) over a
// shared 32x32 multiplier. There are two multiplies per iteration:
//   U = 2^32 - d*X        (clamped to 0 once d*X reaches 2^32)
//   X = X + (X*U)>>32     (saturating)
// Optional build macro NR_EARLY_EXIT_EN: when it is defined, the block
// finishes as soon as a correction term C comes out zero.
`timescale 1ns/1ps
module nr_recip_ctrl #(
  parameter int ITERS = 3  // iteration count, 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] d,
  output logic        busy,
  output logic        done,
  output logic [31:0] recip,
  output logic        err,
  output logic        mul_req,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ack,
  input  logic [63:0] mul_p
);

  typedef enum logic [2:0] {IDLE, GUESS, MUL1, MUL2, UPDATE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] d_reg, d_next;
  logic [31:0] x_reg, x_next;
  logic [31:0] u_reg, u_next;
  logic [31:0] c_reg, c_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] recip_reg, recip_next;
  logic        err_reg, err_next;
  logic        mul_req_reg, mul_req_next;
  logic [31:0] mul_a_reg, mul_a_next;
  logic [31:0] mul_b_reg, mul_b_next;
  logic [32:0] sum_upd;

  // Index of the most significant set bit. An input of 0 never reaches here.
  function automatic logic [4:0] msb_idx(input logic [31:0] v);
    msb_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) msb_idx = 5'(i);
    end
  endfunction

  // X + C, with one extra bit so that saturation can be detected.
  assign sum_upd = {1'b0, x_reg} + {1'b0, c_reg};

  // State and datapath registers. Reset acts immediately, even mid-request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      d_reg       <= '0;
      x_reg       <= '0;
      u_reg       <= '0;
      c_reg       <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      recip_reg   <= '0;
      err_reg     <= 1'b0;
      mul_req_reg <= 1'b0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      d_reg       <= d_next;
      x_reg       <= x_next;
      u_reg       <= u_next;
      c_reg       <= c_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      recip_reg   <= recip_next;
      err_reg     <= err_next;
      mul_req_reg <= mul_req_next;
      mul_a_reg   <= mul_a_next;
      mul_b_reg   <= mul_b_next;
    end
  end

  // Next-state and next-value logic. Each multiply takes two phases: in the
  // cycle where mul_req is low, the operands are loaded and the request is
  // raised. The block then waits for the ack with everything held steady.
  always_comb begin
    state_next   = state_reg;
    d_next       = d_reg;
    x_next       = x_reg;
    u_next       = u_reg;
    c_next       = c_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    recip_next   = recip_reg;
    err_next     = err_reg;
    mul_req_next = mul_req_reg;
    mul_a_next   = mul_a_reg;
    mul_b_next   = mul_b_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          d_next    = d;
          busy_next = 1'b1;
          if (d == 32'd0) begin
            x_next     = 32'hFFFF_FFFF;
            state_next = DONE;
          end else begin
            state_next = GUESS;
          end
        end
      end
      GUESS: begin
        x_next     = 32'h8000_0000 >> msb_idx(d_reg);
        cnt_next   = 4'd0;
        state_next = MUL1;
      end
      MUL1: begin
        if (!mul_req_reg) begin
          mul_req_next = 1'b1;
          mul_a_next   = d_reg;
          mul_b_next   = x_reg;
        end else if (mul_ack) begin
          mul_req_next = 1'b0;
          // 2^32 - P computed modulo 2^32; P is nonzero because d and X are.
          u_next       = (mul_p[63:32] == 32'd0) ? (32'd0 - mul_p[31:0]) : 32'd0;
          state_next   = MUL2;
        end
      end
      MUL2: begin
        if (!mul_req_reg) begin
          mul_req_next = 1'b1;
          mul_a_next   = x_reg;
          mul_b_next   = u_reg;
        end else if (mul_ack) begin
          mul_req_next = 1'b0;
          c_next       = mul_p[63:32];
          state_next   = UPDATE;
        end
      end
      UPDATE: begin
        x_next   = sum_upd[32] ? 32'hFFFF_FFFF : sum_upd[31:0];
        cnt_next = cnt_reg + 4'd1;
`ifdef NR_EARLY_EXIT_EN
        if (c_reg == 32'd0)                   state_next = DONE;
        else if ((cnt_reg + 4'd1) < 4'(ITERS)) state_next = MUL1;
        else                                  state_next = DONE;
`else
        if ((cnt_reg + 4'd1) < 4'(ITERS)) state_next = MUL1;
        else                              state_next = DONE;
`endif
      end
      DONE: begin
        recip_next = x_reg;
        err_next   = (d_reg == 32'd0);
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign recip   = recip_reg;
  assign err     = err_reg;
  assign mul_req = mul_req_reg;
  assign mul_a   = mul_a_reg;
  assign mul_b   = mul_b_reg;

endmodule

// File: tb/tb_nr_recip_ctrl.sv
// tb_nr_recip_ctrl: table-driven bench with a scoreboard, plus a behavioural
// multiplier/arbiter model. That model either acks immediately or after a
// random 0..5 cycles.
`timescale 1ns/1ps
module tb_nr_recip_ctrl;
  localparam int ITERS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] d = '0;
  logic        busy, done, err, mul_req;
  logic [31:0] recip, mul_a, mul_b;
  logic        mul_ack = 1'b0;
  logic [63:0] mul_p = '0;

  nr_recip_ctrl #(.ITERS(ITERS)) dut (
    .clk(clk), .rst(rst), .start(start), .d(d), .busy(busy), .done(done),
    .recip(recip), .err(err), .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] recip;
    logic        err;
    int          nreq;
    int          lat;   // -1: do not check latency
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t tbl[8];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int n_req = 0, stab_err = 0, gap_err = 0;
  bit rand_mode = 0, hold_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference Newton-Raphson computation written directly from the algorithm.
  function automatic logic [31:0] nr_ref(input logic [31:0] dv, output int nreq);
    logic [63:0] p, prod;
    logic [31:0] x, u, c;
    logic [32:0] s;
    int m;
    nreq = 0;
    if (dv == 0) return 32'hFFFF_FFFF;
    m = 0;
    for (int i = 0; i < 32; i++) if (dv[i]) m = i;
    x = 32'h8000_0000 >> m;
    for (int it = 0; it < ITERS; it++) begin
      p = 64'(dv) * 64'(x);
      u = (p < 64'h1_0000_0000) ? 32'(64'h1_0000_0000 - p) : 32'd0;
      prod = 64'(x) * 64'(u);
      c = prod[63:32];
      nreq += 2;
      s = 33'(x) + 33'(c);
      x = s[32] ? 32'hFFFF_FFFF : s[31:0];
`ifdef NR_EARLY_EXIT_EN
      if (c == 0) break;
`endif
    end
    return x;
  endfunction

  // Multiplier/arbiter model. It acks after a chosen delay, and it watches
  // operand stability and the idle gap after each ack. While mul_req is low
  // it drives junk acks in random mode.
  initial begin : mul_model
    bit in_req = 0, prev_ack = 0;
    int dly = 0, wcnt = 0;
    logic [31:0] cap_a = '0, cap_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mul_ack = 0; in_req = 0; prev_ack = 0;
      end else if (mul_req) begin
        if (prev_ack) gap_err++;
        if (!in_req) begin
          in_req = 1; n_req++; cap_a = mul_a; cap_b = mul_b; wcnt = 0;
          dly = rand_mode ? int'($urandom_range(0, 5)) : 0;
        end else if (mul_a !== cap_a || mul_b !== cap_b) begin
          stab_err++;
        end
        if (!(hold_mode && n_req >= 2) && wcnt >= dly) begin
          mul_ack = 1; mul_p = 64'(mul_a) * 64'(mul_b); in_req = 0; prev_ack = 1;
        end else begin
          mul_ack = 0; mul_p = {$urandom, $urandom}; wcnt++; prev_ack = 0;
        end
      end else begin
        prev_ack = 0; in_req = 0;
        mul_ack = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        mul_p = {$urandom, $urandom};
      end
    end
  end

  // Scoreboard monitor: it pops one expectation for each done pulse.
  initial begin : monitor
    bit prev_done = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 0;
      end else begin
        if (prev_done) chk("done_one_cycle", 64'(done), 64'd0);
        if (done) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no done");
          end else begin
            e = sb.pop_front();
            chk("recip", 64'(recip), 64'(e.recip));
            chk("err", 64'(err), 64'(e.err));
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("mul_requests", 64'(n_req), 64'(e.nreq));
            chk("operand_stability_errs", 64'(stab_err), 64'd0);
            chk("req_gap_errs", 64'(gap_err), 64'd0);
            if (e.lat >= 0) chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            $display("txn d=%08h recip=%08h err=%0d reqs=%0d lat=%0d",
                     e.d, recip, err, n_req, cyc - e.t0);
          end
        end
        prev_done = done;
      end
    end
  end

  // Run one reciprocal. In noisy mode start and d are toggled while busy.
  task automatic run_op(input exp_t v, input bit noisy);
    exp_t e;
    @(negedge clk);
    n_req = 0; stab_err = 0; gap_err = 0;
    start = 1; d = v.d;
    e = v; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 0; d = $urandom;
    for (int k = 0; k < 2000 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (noisy && busy) begin start = 1'($urandom_range(0, 1)); d = $urandom; end
      else start = 0;
    end
    start = 0;
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done within bound for d=%08h, expected done", v.d);
      sb.delete();
    end
  endtask

  initial begin : main
    exp_t v;
    int nr;
    logic [31:0] rv;
    logic [31:0] extra_d[4];

    // Fixed vectors with known answers, then more vectors scored by the reference.
    tbl[0] = '{d: 32'd3,          recip: 32'h5555_0000, err: 0, nreq: 6, lat: 18, t0: 0};
    tbl[1] = '{d: 32'd1,          recip: 32'hFF00_0000, err: 0, nreq: 6, lat: 18, t0: 0};
`ifdef NR_EARLY_EXIT_EN
    tbl[2] = '{d: 32'h8000_0000,  recip: 32'h0000_0001, err: 0, nreq: 2, lat: 8,  t0: 0};
`else
    tbl[2] = '{d: 32'h8000_0000,  recip: 32'h0000_0001, err: 0, nreq: 6, lat: 18, t0: 0};
`endif
    tbl[3] = '{d: 32'd0,          recip: 32'hFFFF_FFFF, err: 1, nreq: 0, lat: 2,  t0: 0};
    extra_d[0] = 32'd7; extra_d[1] = 32'd1000; extra_d[2] = 32'hFFFF_FFFF; extra_d[3] = 32'h0001_2345;
    for (int i = 0; i < 4; i++) begin
      rv = nr_ref(extra_d[i], nr);
      tbl[4 + i] = '{d: extra_d[i], recip: rv, err: 0, nreq: nr, lat: 3 + 5 * (nr / 2), t0: 0};
    end

    // Outputs while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_recip", 64'(recip), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_mul_req", 64'(mul_req), 0);
    chk("rst_mul_a", 64'(mul_a), 0);
    chk("rst_mul_b", 64'(mul_b), 0);
    rst = 0;

    // Zero-wait multiplier, every vector in the table.
    for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b0);

    // Random ack delays, junk acks while idle, start/d noise while busy.
    rand_mode = 1;
    v = tbl[0]; v.lat = -1;
    for (int i = 0; i < 3; i++) run_op(v, 1'b1);
    v = tbl[4]; v.lat = -1;
    run_op(v, 1'b1);
    rand_mode = 0;

    // Reset while the MUL2 request waits for an ack.
    hold_mode = 1;
    @(negedge clk);
    start = 1; d = 32'd3; n_req = 0;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 200 && !(n_req >= 2 && mul_req); k++) @(negedge clk);
    chk("mul_req_before_rst", 64'(mul_req), 1);
    rst = 1;
    #1;
    chk("midrst_mul_req", 64'(mul_req), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_done", 64'(done), 0);
    chk("midrst_recip", 64'(recip), 0);
    chk("midrst_err", 64'(err), 0);
    chk("midrst_mul_a", 64'(mul_a), 0);
    chk("midrst_mul_b", 64'(mul_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0; hold_mode = 0;
    run_op(tbl[0], 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nr_recip_ctrl.md
NR_RECIP_CTRL -- requirements
Module: nr_recip_ctrl

Interface
REQ-001 Parameter ITERS, default 3, Newton-Raphson iteration count; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 start  in  1  request a reciprocal of d; sampled only in IDLE.
REQ-005 d  in  32  unsigned divisor.
REQ-006 busy  out  1  high from the cycle after an accepted start until done.
REQ-007 done  out  1  one-cycle pulse; recip and err valid in that cycle and held until the next accepted start.
REQ-008 recip  out  32  reciprocal estimate, approximately 2^32/d, unsigned.
REQ-009 err  out  1  set with done when d was 0.
REQ-010 mul_req  out  1  shared 32x32 multiplier request.
REQ-011 mul_a, mul_b  out  32 each  multiplier operands.
REQ-012 mul_ack  in  1  grant/complete strobe from the multiplier arbiter.
REQ-013 mul_p  in  64  unsigned product, valid in the cycle mul_ack is high.

Function
REQ-014 States: IDLE, GUESS, MUL1, MUL2, UPDATE, DONE.
REQ-015 IDLE: on start, latch d and go to GUESS; if d==0, go to DONE with recip=0xFFFFFFFF, err=1, and issue no multiplier request.
REQ-016 GUESS: X0 = 2^(31-m), where m is the index of the most significant set bit of d; iteration counter cleared; next state MUL1.
REQ-017 MUL1: mul_a=d, mul_b=X, mul_req=1 until mul_ack; on ack, P=mul_p; U=2^32-P if P<2^32, else U=0.
REQ-018 MUL2: mul_a=X, mul_b=U, mul_req=1 until mul_ack; on ack, C=mul_p[63:32].
REQ-019 UPDATE: X = X+C, saturating at 0xFFFFFFFF; counter increments; go to MUL1 if counter<ITERS, else DONE.
REQ-020 mul_req, mul_a and mul_b remain stable while waiting; mul_req drops in the cycle after ack and stays low at least one cycle between transactions.
REQ-021 mul_ack is ignored when mul_req is low; ack can arrive as early as the first cycle of the request, and the wait for it is unbounded.
REQ-022 DONE: recip=X, err=0 (or the value set by REQ-015); done=1 for one cycle; return to IDLE.
REQ-023 Latency with zero-wait ack: 2 + 5*ITERS + 1 cycles from start to done.
REQ-024 start while busy is ignored; d changes after acceptance have no effect.

Reset
REQ-025 rst forces IDLE immediately, including mid-transaction; mul_req drops within the same cycle, without waiting for ack.
REQ-026 Reset values: busy=0, done=0, recip=0, err=0, mul_req=0, mul_a=0, mul_b=0, counter=0.

Configuration
REQ-027 Macro NR_EARLY_EXIT_EN.
REQ-028 Defined: in UPDATE, if C==0 the block goes to DONE regardless of the counter.
REQ-029 Undefined: exactly ITERS iterations always execute.

Verification
REQ-030 d=3, ITERS=3, ack immediate -> 6 transactions, recip=0x55550000, err=0, done 18 cycles after start.
REQ-031 d=1, ITERS=3 -> recip=0xFF000000, err=0.
REQ-032 d=0x80000000 -> recip=0x00000001; with NR_EARLY_EXIT_EN, 2 transactions; without it, 6 transactions.
REQ-033 d=0 -> done the cycle after IDLE exit, recip=0xFFFFFFFF, err=1, mul_req never asserted.
REQ-034 d=3 with mul_ack delayed 0..5 random cycles per request -> operands stable while mul_req high, recip=0x55550000.
REQ-035 rst pulsed while mul_req high in MUL2 -> mul_req=0 immediately, all outputs at reset values, next start d=3 completes correctly.
